// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared divider definitions for the ALU, decoder and divider
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ON   = 2'd1,
      DIV_END  = 2'd2
   } div_state_t;

   localparam int DIV_ITER = 32;

   // alucontrol codes the decoder maps onto i_start / i_signed_div
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one restoring-division step: shift, trial subtract, restore
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic [WIDTH-1:0] i_dvd,
   input  logic [WIDTH-1:0] i_dsr,
   output logic [WIDTH:0]   o_rem,
   output logic [WIDTH-1:0] o_dvd
);

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_diff;
   logic             w_borrow;

   // the quotient bits shift into the dividend register as its bits shift out
   assign w_shift  = {i_rem, i_dvd[WIDTH-1]};
   assign w_diff   = w_shift - {2'b00, i_dsr};
   assign w_borrow = w_diff[WIDTH+1];
   assign o_rem    = w_borrow ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
   assign o_dvd    = {i_dvd[WIDTH-2:0], ~w_borrow};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 DIV/DIVU unit with EX-stage stall handshake
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_ITER
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_signed_div,
   input  logic               i_annul,
   input  logic [WIDTH-1:0]   i_num1,
   input  logic [WIDTH-1:0]   i_num2,
   output logic [2*WIDTH-1:0] o_result,
   output logic               o_ready,
   output logic               o_stall_req
);

   localparam int CW = $clog2(WIDTH) + 1;

   div_state_t         r_state;
   div_state_t         w_state_nxt;
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_dvd;
   logic [WIDTH-1:0]   r_dsr;
   logic               r_qneg;
   logic               r_rneg;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_result;

   logic [WIDTH:0]     w_rem_nxt;
   logic [WIDTH-1:0]   w_quo_nxt;
   logic [WIDTH-1:0]   w_num1_mag;
   logic [WIDTH-1:0]   w_num2_mag;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;
   logic               w_cnt_last;
   logic               w_div_zero;

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem (r_rem),
      .i_dvd (r_dvd),
      .i_dsr (r_dsr),
      .o_rem (w_rem_nxt),
      .o_dvd (w_quo_nxt)
   );

   assign w_num1_mag = (i_signed_div && i_num1[WIDTH-1]) ? -i_num1 : i_num1;
   assign w_num2_mag = (i_signed_div && i_num2[WIDTH-1]) ? -i_num2 : i_num2;
   assign w_quo_fix  = r_qneg ? -w_quo_nxt : w_quo_nxt;
   assign w_rem_fix  = r_rneg ? -w_rem_nxt[WIDTH-1:0] : w_rem_nxt[WIDTH-1:0];
   assign w_cnt_last = (r_cnt == CW'(WIDTH - 1));
   assign w_div_zero = (i_num2 == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= DIV_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_annul) begin
         w_state_nxt = DIV_IDLE;
      end else begin
         case (r_state)
            DIV_IDLE: if (i_start) w_state_nxt = w_div_zero ? DIV_END : DIV_ON;
            DIV_ON:   if (w_cnt_last) w_state_nxt = DIV_END;
            default:  w_state_nxt = DIV_IDLE;
         endcase
      end
   end

   always_comb begin
      o_ready     = (r_state == DIV_END) && !i_annul;
      o_stall_req = ((r_state == DIV_IDLE) && i_start && !i_annul) || (r_state == DIV_ON);
   end

   // a flush freezes the datapath; the result register keeps the last good value
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rem    <= '0;
         r_dvd    <= '0;
         r_dsr    <= '0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (!i_annul) begin
         case (r_state)
            DIV_IDLE: begin
               if (i_start) begin
                  if (w_div_zero) begin
                     r_result <= '0;
                  end else begin
                     r_dvd  <= w_num1_mag;
                     r_dsr  <= w_num2_mag;
                     r_qneg <= i_signed_div && (i_num1[WIDTH-1] ^ i_num2[WIDTH-1]);
                     r_rneg <= i_signed_div && i_num1[WIDTH-1];
                     r_rem  <= '0;
                     r_cnt  <= '0;
                  end
               end
            end
            DIV_ON: begin
               r_rem <= w_rem_nxt;
               r_dvd <= w_quo_nxt;
               r_cnt <= r_cnt + CW'(1);
               if (w_cnt_last) r_result <= {w_rem_fix, w_quo_fix};
            end
            default: ;
         endcase
      end
   end

   assign o_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;

   logic        clk;
   logic        i_rst;
   logic        i_start;
   logic        i_signed_div;
   logic        i_annul;
   logic [31:0] i_num1;
   logic [31:0] i_num2;
   logic [63:0] o_result;
   logic        o_ready;
   logic        o_stall_req;

   int          n_cmp;
   int          n_err;
   logic [63:0] exp_q[$];
   logic [63:0] last_exp;

   div_unit #(.WIDTH(32)) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_signed_div (i_signed_div),
      .i_annul      (i_annul),
      .i_num1       (i_num1),
      .i_num2       (i_num2),
      .o_result     (o_result),
      .o_ready      (o_ready),
      .o_stall_req  (o_stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ma, mb, q, r;
      if (b == 32'd0) return 64'd0;
      ma = (sgn && a[31]) ? (~a + 32'd1) : a;
      mb = (sgn && b[31]) ? (~b + 32'd1) : b;
      q  = ma / mb;
      r  = ma % mb;
      if (sgn && (a[31] ^ b[31])) q = ~q + 32'd1;
      if (sgn && a[31]) r = ~r + 32'd1;
      return {r, q};
   endfunction

   // Entered just after a rising edge: that cycle is cycle 0 of the operation.
   // abort_cyc < 0 means a normal run; otherwise annul (or rst) is driven in that cycle.
   task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int rdy_cyc,
                         input int abort_cyc, input bit abort_rst, input bit spam);
      int  last_c;
      bit  exp_stall;
      bit  exp_ready;
      if (abort_cyc < 0) exp_q.push_back(exp);
      last_c = (abort_cyc < 0) ? rdy_cyc : abort_cyc + 1;
      i_start      = 1'b1;
      i_signed_div = sgn;
      i_num1       = a;
      i_num2       = b;
      for (int c = 0; c <= last_c; c++) begin
         if (c > 0) begin
            i_start = spam && (c >= 5) && (c <= 30);
            if (spam) begin
               i_signed_div = 1'($urandom);
               i_num1       = $urandom;
               i_num2       = $urandom;
            end
            i_annul = (c == abort_cyc) && !abort_rst;
            i_rst   = (c == abort_cyc) && abort_rst;
         end
         @(negedge clk);
         exp_stall = (c < rdy_cyc) && !(abort_cyc >= 0 && c > abort_cyc);
         exp_ready = (abort_cyc < 0) && (c == rdy_cyc);
         chk($sformatf("stall_c%0d", c), {63'd0, o_stall_req}, {63'd0, exp_stall});
         chk($sformatf("ready_c%0d", c), {63'd0, o_ready}, {63'd0, exp_ready});
         if (o_ready && exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            chk("result", o_result, last_exp);
         end
         if (abort_cyc >= 0 && c == abort_cyc + 1) begin
            if (abort_rst) last_exp = 64'd0;
            chk(abort_rst ? "result_after_rst" : "result_after_annul", o_result, last_exp);
         end
         @(posedge clk);
         #1;
      end
      i_start = 1'b0;
      i_annul = 1'b0;
      i_rst   = 1'b0;
      chk("sb_drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      bit          sgn;
      logic [31:0] a, b;
      n_cmp        = 0;
      n_err        = 0;
      last_exp     = 64'd0;
      i_rst        = 1'b1;
      i_start      = 1'b0;
      i_signed_div = 1'b0;
      i_annul      = 1'b0;
      i_num1       = 32'd0;
      i_num2       = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      i_rst = 1'b0;
      @(negedge clk);
      chk("rst_result", o_result, 64'd0);
      chk("rst_ready", {63'd0, o_ready}, 64'd0);
      chk("rst_stall", {63'd0, o_stall_req}, 64'd0);
      @(posedge clk);
      #1;

      run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, -1, 1'b0, 1'b0);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, -1, 1'b0, 1'b0);
      run_op(1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33, -1, 1'b0, 1'b0);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, -1, 1'b0, 1'b0);
      run_op(1'b0, 32'd100, 32'd7, 64'd0, 33, 10, 1'b0, 1'b0);
      run_op(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33, -1, 1'b0, 1'b0);
      run_op(1'b1, 32'd5, 32'd0, 64'd0, 1, -1, 1'b0, 1'b0);
      run_op(1'b0, 32'd100, 32'd7, 64'd0, 33, 20, 1'b1, 1'b0);
      run_op(1'b1, 32'h8000_0001, 32'd3, {32'hFFFF_FFFF, 32'hD555_5556}, 33, -1, 1'b0, 1'b1);

      for (int k = 0; k < 6; k++) begin
         sgn = 1'($urandom);
         a   = $urandom;
         b   = (k % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (b == 32'd0) b = 32'd1;
         if (k == 2) b = 32'hFFFF_FFF3;
         run_op(sgn, a, b, ref_div(sgn, a, b), 33, -1, 1'b0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divider for the MIPS core's DIV/DIVU instructions. These are the operations the combinational ALU does not implement.
- The EX stage hands it the two operands and a start request. The unit raises a stall request back to the pipeline while it works. It then returns {remainder, quotient} for the HI/LO write.
- It is the responder end of the EX-stage stall/ready handshake.
- Algorithm: radix-2 restoring division, one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand width in bits. The result is 2*WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a divide. Sampled only in IDLE.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled with start.
- annul  in  1  pipeline flush or exception. Cancels any operation in progress.
- num1  in  WIDTH  dividend. Sampled with start.
- num2  in  WIDTH  divisor. Sampled with start.
- result  out  2*WIDTH  {HI = remainder, LO = quotient}.
- ready  out  1  one-cycle pulse; result is valid in that cycle.
- stall_req  out  1  combinational request for the pipeline to hold EX.

Behaviour:
- Reset (rst=1 at a clock edge) has priority over every other input. After reset: state=IDLE, result=0, ready=0, the iteration counter is 0, and stall_req=0.
- States: IDLE, ON, END.
- Numbering: cycle 0 is the cycle in which start=1 is sampled in IDLE.
- IDLE, start=1, annul=0, num2!=0 (cycle 0):
  - Latch the operands.
  - If signed_div=1, replace each negative operand by its two's complement magnitude.
  - Record q_neg = num1[31]^num2[31] and r_neg = num1[31].
  - Clear the partial remainder; counter=0; next state ON.
- IDLE, start=1, annul=0, num2==0: next state END with result=0. ready=1 in cycle 1. Divide-by-zero is architecturally undefined; the team fixes it at 0.
- ON (cycles 1..32), at each edge:
  - Shift {remainder, dividend} left by one.
  - Trial subtract the divisor magnitude.
  - If the trial does not borrow, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
  - counter++.
  - On the edge where counter reaches 31 (end of cycle 32): apply the sign fix-up, write result, and go to END.
- Sign fix-up (signed_div=1 only):
  - Quotient is negated when q_neg=1.
  - Remainder is negated when r_neg=1.
  - DIVU results are used unmodified.
- END (cycle 33): ready=1 for exactly this cycle, then the next edge returns to IDLE.
- result holds its value until the next accepted start or reset. It is not cleared on IDLE.
- stall_req = (state==IDLE & start & ~annul) | (state==ON). It is 0 in END, so the pipeline advances in the ready cycle.
- start while in ON or END is ignored. No queueing is done. A start held high through END is accepted again in the following IDLE cycle.
- annul=1 in any state forces next state IDLE and ready=0. result is not updated, and a start in the same cycle is ignored.
- Overflow case: 0x80000000 / 0xFFFFFFFF, signed, gives quotient 0x80000000 and remainder 0 (wrap). No trap is raised.
- Arithmetic: the partial remainder is WIDTH+1 bits wide so the trial subtract can show a borrow. All other datapath registers are WIDTH bits.

Decomposition:
- Shared package (defines header used by the ALU and decoder):
  - State encodings DIV_IDLE, DIV_ON, DIV_END.
  - DIV_ITER = 32.
  - Constants EXE_DIV_OP and EXE_DIVU_OP, so the decoder generates start and signed_div from alucontrol.
- One natural sub-module, div_step: a combinational one-bit shift/trial-subtract slice instantiated once inside div_unit. Everything else stays in div_unit.

Test Plan:
- DIVU, num1=100, num2=7, start one cycle → stall_req high in cycles 0..32; ready only in cycle 33; result = {32'd2, 32'd14}.
- DIV, num1=-7 (0xFFFFFFF9), num2=2 → result = {0xFFFFFFFF, 0xFFFFFFFD}, i.e. remainder -1, quotient -3. Same operands with DIVU → quotient 0x7FFFFFFC, remainder 1.
- DIV, num1=0x80000000, num2=0xFFFFFFFF → ready in cycle 33; result = {0x00000000, 0x80000000}.
- num2=0, start → ready in cycle 1; result=0; stall_req high only in cycle 0.
- Start 100/7, assert annul in cycle 10 → state IDLE in cycle 11; ready never pulses; result keeps its previous value; a new start in cycle 12 completes normally with ready in cycle 45.
- Assert rst in cycle 20 of an operation → cycle 21: ready=0, result=0, stall_req=0. start pulses in cycles 5..30 of a fresh operation are ignored, and ready occurs only in cycle 33.
